// File: rtl/uart_tx_engine.sv
// uart_tx_engine: TX FIFO plus serialiser for the UART line.
// Optional feature macro: UART_TX_CTS_EN (when defined, a new frame may only
// leave IDLE while cts_n is low; otherwise cts_n is ignored).
//
// state   | meaning
// IDLE    | line high, waiting for a queued word
// LOAD    | pop word, latch line control and parity for this frame
// START   | start bit (0)
// DATA    | data bits, LSB first
// PARITY  | parity bit
// STOP    | stop bit(s), 1, 1.5 or 2 bit times
module uart_tx_engine #(
   parameter int DATA_W     = 8,
   parameter int FIFO_AW    = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic               clk,
   input  logic               wb_rst_i,
   input  logic               enable,
   input  logic               tf_push,
   input  logic [DATA_W-1:0]  tf_data,
   input  logic               tx_reset,
   input  logic [3:0]         char_len,
   input  logic               parity_en,
   input  logic               parity_even,
   input  logic               parity_stick,
   input  logic               stop2,
   input  logic               brk,
   input  logic               cts_n,
   output logic               stx_pad_o,
   output logic [FIFO_AW:0]   tf_count,
   output logic               tf_full,
   output logic               overrun,
   output logic               busy,
   output logic [2:0]         state
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TW    = $clog2(2 * OVERSAMPLE);
   localparam logic [TW-1:0] T_BIT    = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_STOP15 = TW'(3 * OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_STOP2  = TW'(2 * OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    count_q;
   logic                overrun_q;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [3:0]          len_q, len_d, bit_q, bit_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic                par_q, par_d, pen_q, pen_d, stop2_q, stop2_d;
   logic                stx_q, stx_d;

   logic                full, load_ok, pop, push_ok, cts_ok, par_bit;
   logic [3:0]          eff_len;
   logic [DATA_W-1:0]   len_mask, rd_data;
   logic [TW-1:0]       stop_ticks;

   assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
   assign rd_data = mem_q[rd_ptr_q];
   assign load_ok = (count_q != '0) && !tx_reset;
   assign pop     = enable && (state_q == S_LOAD) && load_ok;
   assign push_ok = tf_push && !tx_reset && (!full || pop);

`ifdef UART_TX_CTS_EN
   assign cts_ok = ~cts_n;
`else
   logic unused_cts;
   assign cts_ok     = 1'b1;
   assign unused_cts = cts_n;
`endif

   // Effective character length, parity of the bits actually sent, stop length.
   always_comb begin
      if (char_len < 4'd5)               eff_len = 4'd5;
      else if (char_len > 4'(DATA_W))    eff_len = 4'(DATA_W);
      else                               eff_len = char_len;
      len_mask = '0;
      for (int i = 0; i < DATA_W; i++) len_mask[i] = (4'(i) < eff_len);
      if (parity_stick)     par_bit = ~parity_even;
      else if (parity_even) par_bit = ^(rd_data & len_mask);
      else                  par_bit = ~(^(rd_data & len_mask));
      if (!stop2_q)            stop_ticks = T_BIT;
      else if (len_q == 4'd5)  stop_ticks = T_STOP15;
      else                     stop_ticks = T_STOP2;
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= tf_data;
   end

   // FIFO pointers, occupancy and sticky overrun.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else if (tx_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (tf_push && full && !pop) overrun_q <= 1'b1;
      end
   end

   // Serialiser state and datapath registers.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         len_q   <= 4'd5;
         bit_q   <= '0;
         tick_q  <= '0;
         par_q   <= 1'b0;
         pen_q   <= 1'b0;
         stop2_q <= 1'b0;
         stx_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         len_q   <= len_d;
         bit_q   <= bit_d;
         tick_q  <= tick_d;
         par_q   <= par_d;
         pen_q   <= pen_d;
         stop2_q <= stop2_d;
         stx_q   <= stx_d;
      end
   end

   // Next-state logic; the line level is derived from the next state so it
   // changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      len_d   = len_q;
      bit_d   = bit_q;
      tick_d  = tick_q;
      par_d   = par_q;
      pen_d   = pen_q;
      stop2_d = stop2_q;
      stx_d   = stx_q;
      if (enable) begin
         case (state_q)
            S_IDLE: if (count_q != '0 && cts_ok) state_d = S_LOAD;
            S_LOAD: begin
               if (load_ok) begin
                  shift_d = rd_data;
                  len_d   = eff_len;
                  par_d   = par_bit;
                  pen_d   = parity_en;
                  stop2_d = stop2;
                  tick_d  = T_BIT;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_START: begin
               if (tick_q == '0) begin
                  state_d = S_DATA;
                  tick_d  = T_BIT;
                  bit_d   = len_q - 4'd1;
               end else begin
                  tick_d = tick_q - 1'b1;
               end
            end
            S_DATA: begin
               if (tick_q == '0) begin
                  if (bit_q == '0) begin
                     state_d = pen_q ? S_PARITY : S_STOP;
                     tick_d  = pen_q ? T_BIT : stop_ticks;
                  end else begin
                     bit_d   = bit_q - 4'd1;
                     shift_d = shift_q >> 1;
                     tick_d  = T_BIT;
                  end
               end else begin
                  tick_d = tick_q - 1'b1;
               end
            end
            S_PARITY: begin
               if (tick_q == '0) begin
                  state_d = S_STOP;
                  tick_d  = stop_ticks;
               end else begin
                  tick_d = tick_q - 1'b1;
               end
            end
            S_STOP: begin
               if (tick_q == '0) state_d = S_IDLE;
               else              tick_d  = tick_q - 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
         case (state_d)
            S_START:  stx_d = 1'b0;
            S_DATA:   stx_d = shift_d[0];
            S_PARITY: stx_d = par_d;
            default:  stx_d = 1'b1;
         endcase
      end
   end

   assign stx_pad_o = stx_q & ~brk;
   assign tf_count  = count_q;
   assign tf_full   = full;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);
   assign state     = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (DATA_W=8, FIFO_AW=4, OVERSAMPLE=16).
module tb_uart_tx_engine;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          wb_rst_i, enable, tf_push, tx_reset;
   logic          parity_en, parity_even, parity_stick, stop2, brk, cts_n;
   logic [DW-1:0] tf_data;
   logic [3:0]    char_len;
   logic          stx_pad_o, tf_full, overrun, busy;
   logic [AW:0]   tf_count;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];
   int   flen_q[$];

   uart_tx_engine #(.DATA_W(DW), .FIFO_AW(AW), .OVERSAMPLE(OS)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .tf_push(tf_push),
      .tf_data(tf_data), .tx_reset(tx_reset), .char_len(char_len),
      .parity_en(parity_en), .parity_even(parity_even), .parity_stick(parity_stick),
      .stop2(stop2), .brk(brk), .cts_n(cts_n), .stx_pad_o(stx_pad_o),
      .tf_count(tf_count), .tf_full(tf_full), .overrun(overrun), .busy(busy),
      .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Expected per-tick line levels for one frame, from the current line control.
   task automatic queue_frame(input logic [DW-1:0] d);
      int l, n, s;
      logic x, p;
      if (int'(char_len) < 5)       l = 5;
      else if (int'(char_len) > DW) l = DW;
      else                          l = int'(char_len);
      x = 1'b0;
      repeat (OS) exp_q.push_back(1'b0);
      n = OS;
      for (int b = 0; b < l; b++) begin
         x = x ^ d[b];
         repeat (OS) exp_q.push_back(d[b]);
         n += OS;
      end
      if (parity_en) begin
         p = parity_stick ? ~parity_even : (parity_even ? x : ~x);
         repeat (OS) exp_q.push_back(p);
         n += OS;
      end
      s = !stop2 ? OS : ((l == 5) ? (OS * 3) / 2 : 2 * OS);
      repeat (s) exp_q.push_back(1'b1);
      n += s;
      flen_q.push_back(n);
   endtask

   task automatic set_lc(input int len, input logic pen, input logic even,
                         input logic stick, input logic st2);
      char_len = 4'(len); parity_en = pen; parity_even = even;
      parity_stick = stick; stop2 = st2;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      queue_frame(d);
      @(posedge clk); #1;
      tf_push = 1'b1; tf_data = d;
      @(posedge clk); #1;
      tf_push = 1'b0;
   endtask

   // Waits for a start bit, then compares every tick of the frame against the scoreboard.
   task automatic check_frame(input string name, input int exp_gap);
      int gap, n, bad_i;
      logic e, got, got_busy, bad_e;
      gap = 0;
      do begin
         @(negedge clk); gap++;
      end while (stx_pad_o !== 1'b0 && gap < 200);
      checks++;
      if (flen_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: no expected frame queued, required one", name);
         return;
      end
      n = flen_q.pop_front();
      if (stx_pad_o !== 1'b0) begin
         errors++;
         $display("FAIL %s start: stx_pad_o=%b after %0d cycles, required 0", name, stx_pad_o, gap);
         for (int i = 0; i < n; i++) e = exp_q.pop_front();
         return;
      end
      if (exp_gap >= 0) begin
         checks++;
         if (gap - 1 != exp_gap) begin
            errors++;
            $display("FAIL %s gap: %0d idle-high ticks before start, required %0d", name, gap - 1, exp_gap);
         end
      end
      bad_i = -1; got = 1'b0; got_busy = 1'b0; bad_e = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         e = exp_q.pop_front();
         if ((stx_pad_o !== e || busy !== 1'b1) && bad_i < 0) begin
            bad_i = i; got = stx_pad_o; got_busy = busy; bad_e = e;
         end
      end
      checks++;
      if (bad_i >= 0) begin
         errors++;
         $display("FAIL %s frame: tick %0d of %0d stx_pad_o=%b busy=%b, required stx_pad_o=%b busy=1",
                  name, bad_i, n, got, got_busy, bad_e);
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || state !== 3'd0 || stx_pad_o !== 1'b1) begin
         errors++;
         $display("FAIL %s idle: busy=%b state=%0d stx_pad_o=%b, required busy=0 state=0 stx_pad_o=1",
                  name, busy, state, stx_pad_o);
      end
   endtask

   task automatic test_reset;
      wb_rst_i = 1'b1; enable = 1'b1; tf_push = 1'b0; tx_reset = 1'b0; brk = 1'b0;
      cts_n = 1'b0; tf_data = '0;
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (stx_pad_o !== 1'b1) begin errors++; $display("FAIL reset stx_pad_o: %b, required 1", stx_pad_o); end
      checks++; if (tf_count !== '0) begin errors++; $display("FAIL reset tf_count: %0d, required 0", tf_count); end
      checks++; if (tf_full !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset flags: tf_full=%b overrun=%b, required 0 0", tf_full, overrun); end
      checks++; if (busy !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL reset fsm: busy=%b state=%0d, required 0 0", busy, state); end
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
   endtask

   task automatic test_basic_8n1;
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b0);
      push_word(8'h55);
      @(negedge clk);
      checks++;
      if (tf_count !== 5'd1 || state !== 3'd0) begin
         errors++; $display("FAIL basic push: tf_count=%0d state=%0d, required 1 0", tf_count, state);
      end
      @(negedge clk);
      checks++;
      if (state !== 3'd1 || stx_pad_o !== 1'b1) begin
         errors++; $display("FAIL basic load: state=%0d stx_pad_o=%b, required 1 1", state, stx_pad_o);
      end
      check_frame("basic_8n1", 0);
      checks++;
      if (tf_count !== '0) begin errors++; $display("FAIL basic pop: tf_count=%0d, required 0", tf_count); end
      check_idle("basic_8n1");
   endtask

   task automatic test_parity;
      set_lc(7, 1'b1, 1'b1, 1'b0, 1'b0);
      push_word(8'h83);
      check_frame("parity_even", -1);
      check_idle("parity_even");
      set_lc(7, 1'b1, 1'b0, 1'b1, 1'b0);
      push_word(8'h83);
      check_frame("parity_stick", -1);
      check_idle("parity_stick");
      set_lc(8, 1'b1, 1'b0, 1'b0, 1'b0);
      push_word(8'h83);
      check_frame("parity_odd", -1);
      check_idle("parity_odd");
   endtask

   task automatic test_stop2;
      set_lc(5, 1'b0, 1'b0, 1'b0, 1'b1);
      push_word(8'h15);
      check_frame("stop15_len5", -1);
      check_idle("stop15_len5");
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b1);
      push_word(8'hA3);
      check_frame("stop2_len8", -1);
      check_idle("stop2_len8");
   endtask

   task automatic test_clamp;
      set_lc(2, 1'b1, 1'b1, 1'b0, 1'b1);
      push_word(8'hFF);
      check_frame("clamp_low", -1);
      check_idle("clamp_low");
      set_lc(15, 1'b0, 1'b0, 1'b0, 1'b0);
      push_word(8'hC3);
      check_frame("clamp_high", -1);
      check_idle("clamp_high");
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] words[3];
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h81;
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         queue_frame(words[i]);
         @(posedge clk); #1;
         tf_push = 1'b1; tf_data = words[i];
      end
      @(posedge clk); #1;
      tf_push = 1'b0;
      check_frame("b2b_0", -1);
      check_frame("b2b_1", 2);
      check_frame("b2b_2", 2);
      check_idle("b2b");
   endtask

   task automatic test_fifo_full;
      @(posedge clk); #1;
      enable = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         if (i == 16) begin
            checks++;
            if (tf_count !== 5'd16 || tf_full !== 1'b1 || overrun !== 1'b0) begin
               errors++; $display("FAIL fifo_fill: tf_count=%0d tf_full=%b overrun=%b, required 16 1 0", tf_count, tf_full, overrun);
            end
         end
         tf_push = 1'b1; tf_data = 8'(i);
      end
      @(posedge clk); #1;
      tf_push = 1'b0;
      checks++;
      if (tf_count !== 5'd16 || tf_full !== 1'b1 || overrun !== 1'b1) begin
         errors++; $display("FAIL fifo_overrun: tf_count=%0d tf_full=%b overrun=%b, required 16 1 1", tf_count, tf_full, overrun);
      end
      checks++;
      if (state !== 3'd0 || stx_pad_o !== 1'b1) begin
         errors++; $display("FAIL fifo_hold: state=%0d stx_pad_o=%b, required 0 1", state, stx_pad_o);
      end
      tx_reset = 1'b1; tf_push = 1'b1; tf_data = 8'hEE;
      @(posedge clk); #1;
      tx_reset = 1'b0; tf_push = 1'b0;
      checks++;
      if (tf_count !== '0 || overrun !== 1'b0 || tf_full !== 1'b0) begin
         errors++; $display("FAIL fifo_txreset: tf_count=%0d overrun=%b tf_full=%b, required 0 0 0", tf_count, overrun, tf_full);
      end
      enable = 1'b1;
      repeat (4) @(posedge clk);
      check_idle("fifo_after_reset");
   endtask

   task automatic test_rst_mid_frame;
      int n;
      logic s0;
      logic [2:0] st0;
      logic held;
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      tf_push = 1'b1; tf_data = 8'hF0;
      @(posedge clk); #1;
      tf_data = 8'h0F;
      @(posedge clk); #1;
      tf_push = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (state !== 3'd3 && n < 100);
      checks++;
      if (state !== 3'd3) begin errors++; $display("FAIL rst_mid reach_data: state=%0d, required 3", state); end
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      enable = 1'b0;
      @(negedge clk);
      s0 = stx_pad_o; st0 = state; held = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (stx_pad_o !== s0 || state !== st0) held = 1'b0;
      end
      checks++;
      if (!held || st0 !== 3'd3) begin
         errors++; $display("FAIL enable_hold: state=%0d stx_pad_o=%b, required state=3 held at stx_pad_o=%b", state, stx_pad_o, s0);
      end
      @(posedge clk); #1;
      wb_rst_i = 1'b1;
      #1;
      checks++;
      if (stx_pad_o !== 1'b1 || state !== 3'd0 || tf_count !== '0 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid async: stx_pad_o=%b state=%0d tf_count=%0d busy=%b, required 1 0 0 0", stx_pad_o, state, tf_count, busy);
      end
      @(posedge clk); #1;
      wb_rst_i = 1'b0; enable = 1'b1;
      check_idle("rst_mid_after");
   endtask

   task automatic test_brk;
      @(posedge clk); #1;
      brk = 1'b1;
      #1;
      checks++;
      if (stx_pad_o !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL brk_on: stx_pad_o=%b busy=%b, required 0 0", stx_pad_o, busy);
      end
      @(negedge clk);
      checks++;
      if (stx_pad_o !== 1'b0 || state !== 3'd0) begin
         errors++; $display("FAIL brk_hold: stx_pad_o=%b state=%0d, required 0 0", stx_pad_o, state);
      end
      brk = 1'b0;
      #1;
      checks++;
      if (stx_pad_o !== 1'b1) begin errors++; $display("FAIL brk_off: stx_pad_o=%b, required 1", stx_pad_o); end
   endtask

`ifdef UART_TX_CTS_EN
   task automatic test_cts;
      logic ok;
      int n;
      set_lc(8, 1'b0, 1'b0, 1'b0, 1'b0);
      cts_n = 1'b1;
      queue_frame(8'h5A);
      queue_frame(8'h96);
      @(posedge clk); #1;
      tf_push = 1'b1; tf_data = 8'h5A;
      @(posedge clk); #1;
      tf_data = 8'h96;
      @(posedge clk); #1;
      tf_push = 1'b0;
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (stx_pad_o !== 1'b1 || state !== 3'd0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL cts_block: state=%0d stx_pad_o=%b, required 0 1", state, stx_pad_o); end
      @(posedge clk); #1;
      cts_n = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (state === 3'd0 && n < 20);
      @(posedge clk); #1;
      cts_n = 1'b1;
      check_frame("cts_first", -1);
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (stx_pad_o !== 1'b1 || state !== 3'd0 || tf_count !== 5'd1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL cts_wait: state=%0d stx_pad_o=%b tf_count=%0d, required 0 1 1", state, stx_pad_o, tf_count); end
      @(posedge clk); #1;
      cts_n = 1'b0;
      check_frame("cts_second", -1);
      check_idle("cts_second");
   endtask
`endif

   initial begin
      test_reset();
      test_basic_8n1();
      test_parity();
      test_stop2();
      test_clamp();
      test_back_to_back();
      test_fifo_full();
      test_rst_mid_frame();
      test_brk();
`ifdef UART_TX_CTS_EN
      test_cts();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised, second-generation UART transmit engine: an internal power-of-two TX FIFO feeding a serialiser with configurable oversample ratio, character length up to 9 bits, parity modes, 1/1.5/2 stop bits, break, and an overrun flag. It sits between the Wishbone register file (THR writes, line-control fields) and the `stx_pad_o` pin, clocked by the system clock and paced by the baud-generator `enable` strobe.

## Interface
- `DATA_W`, 8 – FIFO word width and maximum character length (legal 5..9)
- `FIFO_AW`, 4 – FIFO depth = 2^FIFO_AW entries
- `OVERSAMPLE`, 16 – enable ticks per bit; even, ≥4
- `clk  in  1` – system clock
- `wb_rst_i  in  1` – reset, asynchronous, active-high
- `enable  in  1` – baud tick, one-`clk` pulse at OVERSAMPLE × baud
- `tf_push  in  1` – write `tf_data` into FIFO
- `tf_data  in  DATA_W` – character to transmit, LSB sent first
- `tx_reset  in  1` – synchronous FIFO flush, also clears `overrun`
- `char_len  in  4` – bits per character; <5 → 5, >DATA_W → DATA_W
- `parity_en, parity_even, parity_stick, stop2, brk  in  1 each` – line control
- `cts_n  in  1` – clear-to-send, active low (used only with `UART_TX_CTS_EN`)
- `stx_pad_o  out  1` – serial output, reset 1
- `tf_count  out  FIFO_AW+1` – FIFO occupancy, reset 0
- `tf_full  out  1` – `tf_count == 2^FIFO_AW`, reset 0
- `overrun  out  1` – sticky, push while full, reset 0
- `busy  out  1` – state ≠ IDLE, reset 0
- `state  out  3` – IDLE=0, LOAD=1, START=2, DATA=3, PARITY=4, STOP=5; reset 0

## Operation
- FIFO: push accepted when not full, or when full and a pop occurs in the same cycle. A push while full with no pop is dropped and sets `overrun`. `tx_reset` zeroes pointers/count and clears `overrun`. It does not abort the frame in flight, and a simultaneous push is discarded.
- FSM advances only on `enable` cycles; with `enable` low all state, counters and `stx_pad_o` hold.
- IDLE: `stx_pad_o`=1. If `tf_count`≠0 → LOAD.
- LOAD (one tick): pop one word; latch shift register, effective `char_len`, and parity bit → START. Parity bit:
  - stick: `~parity_even`
  - even: XOR of the `char_len` low bits
  - odd: inverted XOR
- START: drive 0 for OVERSAMPLE ticks → DATA.
- DATA: drive shift LSB, OVERSAMPLE ticks per bit, `char_len` bits. Then → PARITY if `parity_en`, else → STOP.
- PARITY: drive latched parity bit for OVERSAMPLE ticks → STOP.
- STOP: drive 1 for:
  - OVERSAMPLE ticks if `!stop2`
  - 3·OVERSAMPLE/2 if `stop2` and effective `char_len`==5
  - 2·OVERSAMPLE otherwise
  - then → IDLE.
- Line-control inputs are sampled at LOAD; changes mid-frame affect the next frame only. Exception: `brk`, which forces `stx_pad_o`=0 combinationally at any time while the FSM keeps running.
- `wb_rst_i` mid-frame: immediate return to IDLE, FIFO empty, `stx_pad_o`=1.

## Timing
- Push→count: `tf_count` increments on the `clk` edge after `tf_push`.
- Empty FIFO, `enable` continuously high: push at edge N → IDLE sees count at N+1 → LOAD at N+2 → `stx_pad_o` falls at edge N+3.
- Frame length in ticks = OVERSAMPLE·(1 + char_len + parity_en) + stop ticks.
- Back-to-back frames: STOP→IDLE→LOAD adds exactly 2 idle-high ticks between frames.
- Pop: `tf_count` decrements on the edge ending the LOAD tick.
- `stx_pad_o` is a register output except for the `brk` override.

## Configuration
- `UART_TX_CTS_EN` defined:
  - IDLE→LOAD additionally requires `cts_n`=0, sampled on the enable tick.
  - Deassertion mid-frame does not abort the frame.
  - The next frame is held in IDLE with `stx_pad_o`=1 until `cts_n` returns low.
- `UART_TX_CTS_EN` undefined: `cts_n` is ignored (port retained, unconnected internally).

## Test plan
- Reset, then push 0x55, 8N1, OVERSAMPLE=16, enable every cycle → start edge at 3 cycles after push; line 0,1,0,1,0,1,0,1,0,1 then 1; each bit 16 cycles; `busy` falls after 160 ticks.
- char_len=7, parity_en=1, parity_even=1, push 0x83 → 7 data bits 1,1,0,0,0,0,0, parity 0, stop 1. Repeat with parity_stick=1, parity_even=0 → parity 1.
- char_len=5, stop2=1 → stop high 24 ticks; char_len=8, stop2=1 → 32 ticks.
- Push 17 words with FIFO_AW=4 while the engine is held idle (enable=0) → `tf_full`=1, `overrun`=1, count=16. Then `tx_reset` → count 0, overrun 0.
- Assert `wb_rst_i` mid-DATA → same cycle `stx_pad_o`=1, state=0, count=0. Hold `brk`=1 in IDLE → line 0 while `busy`=0.
- With `UART_TX_CTS_EN`: `cts_n`=1 with 2 words queued → no start bit. Drop `cts_n` → frame starts. Raise `cts_n` mid-frame → frame completes, second frame waits.
